// File: rtl/bch_syndrome_ctrl_if.sv
// Upstream beat stream and downstream syndrome stream of the BCH syndrome controller.
// The master side feeds codeword beats and consumes syndromes; the slave is the controller.
interface bch_syndrome_ctrl_if #(
    parameter int unsigned M    = 13,
    parameter int unsigned NSYN = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_data;
    logic                in_sop;
    logic [NSYN*M-1:0]   synd_out;
    logic                synd_zero;
    logic                synd_valid;
    logic                synd_ready;

    modport master (
        output in_valid, in_data, in_sop, synd_ready,
        input  in_ready, synd_out, synd_zero, synd_valid
    );

    modport slave (
        input  in_valid, in_data, in_sop, synd_ready,
        output in_ready, synd_out, synd_zero, synd_valid
    );
endinterface

// File: rtl/bch_syndrome_ctrl.sv
// Frames 32-bit codeword beats into the parallel syndrome datapath, aborts on framing
// errors and captures final syndromes into a 2-entry FIFO for the key-equation solver.
module bch_syndrome_ctrl #(
    parameter int unsigned CW_BEATS = 256,
    parameter int unsigned BEAT_W   = 9,
    parameter int unsigned M        = 13,
    parameter int unsigned NSYN     = 16
) (
    input  logic                clk,
    input  logic                reset,
    bch_syndrome_ctrl_if.slave  bus,
    output logic                dp_reset,
    output logic [31:0]         dp_bits,
    input  logic [NSYN*M-1:0]   dp_synd,
    output logic                frame_err,
    output logic [15:0]         cw_count
);

    localparam int unsigned SW = NSYN * M;
    localparam logic [BEAT_W-1:0] LastCnt = BEAT_W'(CW_BEATS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StLast, StCapt} state_e;

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] cnt_q, cnt_d;
    logic [31:0]       bits_q, bits_d;
    logic              dpr_q, dpr_d;
    logic              ferr_q, ferr_d;
    logic [15:0]       cw_q;
    logic              accept, push, pop;

    logic [SW:0]       mem_q [2];
    logic [SW:0]       mem_d [2];
    logic [1:0]        count_q, count_d;

    assign accept = bus.in_valid && bus.in_ready;
    assign pop    = bus.synd_valid && bus.synd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept && bus.in_sop) state_d = (CW_BEATS == 1) ? StLast : StRun;
            end
            StRun: begin
                if (!bus.in_valid || bus.in_sop) state_d = StIdle;
                else if (cnt_q == LastCnt)       state_d = StLast;
            end
            StLast: state_d = StCapt;
            StCapt: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.in_ready = 1'b0;
        bits_d       = bits_q;
        dpr_d        = dpr_q;
        cnt_d        = cnt_q;
        ferr_d       = 1'b0;
        push         = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Only start a codeword when its capture slot is guaranteed.
                bus.in_ready = !reset && (count_q < 2'd2);
                dpr_d        = 1'b1;
                bits_d       = '0;
                cnt_d        = '0;
                if (accept) begin
                    if (bus.in_sop) begin
                        bits_d = bus.in_data;
                        dpr_d  = 1'b0;
                        cnt_d  = BEAT_W'(1);
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            StRun: begin
                bus.in_ready = !reset;
                if (!bus.in_valid || bus.in_sop) begin
                    ferr_d = 1'b1;
                    dpr_d  = 1'b1;
                    bits_d = '0;
                    cnt_d  = '0;
                end else begin
                    bits_d = bus.in_data;
                    cnt_d  = cnt_q + BEAT_W'(1);
                end
            end
            StLast: begin
                dpr_d  = 1'b1;
                bits_d = '0;
                cnt_d  = '0;
            end
            StCapt: begin
                push   = 1'b1;
                dpr_d  = 1'b1;
                bits_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            bits_q <= '0;
            dpr_q  <= 1'b1;
            ferr_q <= 1'b0;
            cw_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            bits_q <= bits_d;
            dpr_q  <= dpr_d;
            ferr_q <= ferr_d;
            if (push) cw_q <= cw_q + 16'd1;
        end
    end

    // Head lives in slot 0; vacated slots are zeroed so an empty FIFO reads as zero.
    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        count_d  = count_q;
        if (pop) begin
            mem_d[0] = mem_q[1];
            mem_d[1] = '0;
            count_d  = count_q - 2'd1;
        end
        if (push) begin
            mem_d[count_d[0]] = {dp_synd, dp_synd == '0};
            count_d           = count_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            count_q  <= '0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            count_q  <= count_d;
        end
    end

    assign dp_reset       = dpr_q || reset;
    assign dp_bits        = bits_q;
    assign frame_err      = ferr_q;
    assign cw_count       = cw_q;
    assign bus.synd_valid = (count_q != 2'd0);
    assign bus.synd_out   = mem_q[0][SW:1];
    assign bus.synd_zero  = mem_q[0][0];

endmodule

// File: tb/tb_bch_syndrome_ctrl.sv
// Bench for bch_syndrome_ctrl: drives random codewords through a behavioural syndrome
// datapath and checks captured syndromes against a direct power-sum model over GF(2^13).
module tb_bch_syndrome_ctrl;

    localparam int unsigned CWB   = 4;
    localparam int unsigned BW    = 3;
    localparam int unsigned M     = 13;
    localparam int unsigned NSYN  = 16;
    localparam int unsigned SW    = NSYN * M;
    localparam int unsigned NBITS = 32 * CWB;
    localparam int unsigned GF_N  = 8191;
    localparam logic [M:0]  POLY  = 14'h201B;

    typedef logic [31:0] cw_t [CWB];

    logic            clk = 1'b0;
    logic            reset;
    logic            dp_reset;
    logic [31:0]     dp_bits;
    logic [SW-1:0]   dp_synd;
    logic            frame_err;
    logic [15:0]     cw_count;

    int checks   = 0;
    int failures = 0;
    int exp_count = 0;

    logic [M-1:0] apow [GF_N];
    logic [M-1:0] dps  [NSYN];

    always #5 clk = ~clk;

    bch_syndrome_ctrl_if #(.M(M), .NSYN(NSYN)) bus ();

    bch_syndrome_ctrl #(
        .CW_BEATS (CWB),
        .BEAT_W   (BW),
        .M        (M),
        .NSYN     (NSYN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dp_reset  (dp_reset),
        .dp_bits   (dp_bits),
        .dp_synd   (dp_synd),
        .frame_err (frame_err),
        .cw_count  (cw_count)
    );

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] p;
        logic [M-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) p ^= x;
            x = x[M-1] ? ({x[M-2:0], 1'b0} ^ POLY[M-1:0]) : {x[M-2:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [M-1:0] beat_term(input int k, input logic [31:0] bits);
        logic [M-1:0] t;
        t = '0;
        for (int i = 0; i < 32; i++) if (bits[i]) t ^= apow[(k * (31 - i)) % GF_N];
        return t;
    endfunction

    // Behavioural datapath: Horner update S_k <- S_k * alpha^(32k) + beat contribution.
    always @(posedge clk) begin
        for (int k = 0; k < NSYN; k++) begin
            if (dp_reset) dps[k] <= '0;
            else dps[k] <= gf_mul(dps[k], apow[(32 * (k + 1)) % GF_N]) ^ beat_term(k + 1, dp_bits);
        end
    end

    always_comb begin
        dp_synd = '0;
        for (int k = 0; k < NSYN; k++) dp_synd[M*k +: M] = dps[k];
    end

    // Reference: S_k = sum over set bits at polynomial position p of alpha^(k*p).
    function automatic logic [SW-1:0] ref_synd(input cw_t cw);
        logic [SW-1:0] r;
        logic [M-1:0]  acc;
        int            pos;
        r = '0;
        for (int k = 1; k <= NSYN; k++) begin
            acc = '0;
            for (int b = 0; b < CWB; b++) begin
                for (int i = 0; i < 32; i++) begin
                    if (cw[b][i]) begin
                        pos = NBITS - 1 - (32 * b + i);
                        acc ^= apow[(k * pos) % GF_N];
                    end
                end
            end
            r[M*k-1 -: M] = acc;
        end
        return r;
    endfunction

    task automatic build_tables();
        logic [M:0] a;
        a = 1;
        for (int e = 0; e < GF_N; e++) begin
            apow[e] = a[M-1:0];
            a = a << 1;
            if (a[M]) a ^= POLY;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic rand_cw(output cw_t cw);
        int mode;
        mode = $urandom_range(0, 3);
        for (int b = 0; b < CWB; b++) cw[b] = (mode >= 2) ? $urandom : 32'h0;
        if (mode == 1) cw[$urandom_range(0, CWB - 1)][$urandom_range(0, 31)] = 1'b1;
    endtask

    task automatic send_beat(input logic [31:0] d, input bit sop, output bit ok, output int waits);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sop   = sop;
        waits = 0;
        while (!bus.in_ready && waits < 50) begin
            tick();
            waits++;
        end
        ok = bus.in_ready;
        if (ok) tick();
    endtask

    task automatic send_cw(input cw_t cw, output bit ok, output int first_wait);
        bit okb;
        int w;
        ok = 1'b1;
        first_wait = 0;
        for (int b = 0; b < CWB; b++) begin
            send_beat(cw[b], b == 0, okb, w);
            if (b == 0) first_wait = w;
            if (!okb) begin
                ok = 1'b0;
                break;
            end
        end
        idle_inputs();
    endtask

    task automatic pop_head(output logic [SW-1:0] s, output logic z, output bit ok);
        int n;
        n = 0;
        while (!bus.synd_valid && n < 50) begin
            tick();
            n++;
        end
        ok = bus.synd_valid;
        s  = bus.synd_out;
        z  = bus.synd_zero;
        bus.synd_ready = 1'b1;
        tick();
        bus.synd_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus.synd_ready = 1'b0;
        repeat (3) tick();
        bus.in_valid = 1'b1;
        bus.in_sop   = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", bus.in_ready); end
        checks++; if (dp_reset !== 1'b1) begin failures++; $display("FAIL reset_dp_reset got=%0b exp=1", dp_reset); end
        checks++; if (dp_bits !== 32'h0) begin failures++; $display("FAIL reset_dp_bits got=%0h exp=0", dp_bits); end
        checks++; if (bus.synd_valid !== 1'b0) begin failures++; $display("FAIL reset_synd_valid got=%0b exp=0", bus.synd_valid); end
        checks++; if (bus.synd_out !== '0 || bus.synd_zero !== 1'b0) begin failures++; $display("FAIL reset_synd_out got=%0h/%0b exp=0/0", bus.synd_out, bus.synd_zero); end
        checks++; if (frame_err !== 1'b0 || cw_count !== 16'd0) begin failures++; $display("FAIL reset_err_count got=%0b/%0d exp=0/0", frame_err, cw_count); end
        idle_inputs();
        reset = 1'b0;
        tick();
        checks++; if (bus.in_ready !== 1'b1 || dp_reset !== 1'b1) begin failures++; $display("FAIL idle_after_reset got rdy=%0b dpr=%0b exp 1/1", bus.in_ready, dp_reset); end
    endtask

    task automatic test_zero_cw();
        cw_t cw;
        bit  ok;
        int  w;
        for (int b = 0; b < CWB; b++) cw[b] = 32'h0;
        bus.synd_ready = 1'b1;
        send_cw(cw, ok, w);
        checks++; if (!ok) begin failures++; $display("FAIL zero_send got=timeout exp=accepted"); end
        checks++; if (bus.synd_valid !== 1'b0) begin failures++; $display("FAIL zero_lat_t1 got=%0b exp=0", bus.synd_valid); end
        tick();
        checks++; if (bus.synd_valid !== 1'b0) begin failures++; $display("FAIL zero_lat_t2 got=%0b exp=0", bus.synd_valid); end
        tick();
        exp_count++;
        checks++; if (bus.synd_valid !== 1'b1) begin failures++; $display("FAIL zero_lat_t3 got=%0b exp=1", bus.synd_valid); end
        checks++; if (bus.synd_out !== '0 || bus.synd_zero !== 1'b1) begin failures++; $display("FAIL zero_synd got=%0h/%0b exp=0/1", bus.synd_out, bus.synd_zero); end
        checks++; if (cw_count !== 16'(exp_count)) begin failures++; $display("FAIL zero_count got=%0d exp=%0d", cw_count, exp_count); end
        tick();
        bus.synd_ready = 1'b0;
        checks++; if (bus.synd_valid !== 1'b0) begin failures++; $display("FAIL zero_pop got=%0b exp=0", bus.synd_valid); end
    endtask

    task automatic test_single_error();
        cw_t           cw;
        logic [SW-1:0] s;
        logic          z;
        bit            ok;
        int            w;
        for (int b = 0; b < CWB; b++) cw[b] = 32'h0;
        cw[0] = 32'h1;
        send_cw(cw, ok, w);
        pop_head(s, z, ok);
        exp_count++;
        checks++; if (!ok || s !== ref_synd(cw)) begin failures++; $display("FAIL single_synd got=%0h exp=%0h", s, ref_synd(cw)); end
        checks++; if (s[M-1:0] !== apow[NBITS-1]) begin failures++; $display("FAIL single_s1 got=%0h exp=%0h", s[M-1:0], apow[NBITS-1]); end
        checks++; if (z !== 1'b0) begin failures++; $display("FAIL single_zero got=%0b exp=0", z); end
        checks++; if (cw_count !== 16'(exp_count)) begin failures++; $display("FAIL single_count got=%0d exp=%0d", cw_count, exp_count); end
    endtask

    task automatic test_random();
        cw_t           cw;
        logic [SW-1:0] s;
        logic          z;
        bit            ok;
        int            w;
        for (int n = 0; n < 8; n++) begin
            rand_cw(cw);
            send_cw(cw, ok, w);
            pop_head(s, z, ok);
            exp_count++;
            checks++; if (!ok || s !== ref_synd(cw)) begin failures++; $display("FAIL random_synd[%0d] got=%0h exp=%0h", n, s, ref_synd(cw)); end
            checks++; if (z !== (ref_synd(cw) == '0)) begin failures++; $display("FAIL random_zero[%0d] got=%0b exp=%0b", n, z, ref_synd(cw) == '0); end
        end
        checks++; if (cw_count !== 16'(exp_count)) begin failures++; $display("FAIL random_count got=%0d exp=%0d", cw_count, exp_count); end
    endtask

    task automatic test_back_to_back();
        cw_t           a, b;
        logic [SW-1:0] s;
        logic          z;
        bit            ok;
        int            w;
        rand_cw(a);
        rand_cw(b);
        send_cw(a, ok, w);
        send_cw(b, ok, w);
        checks++; if (w != 2) begin failures++; $display("FAIL b2b_period got_wait=%0d exp_wait=2", w); end
        pop_head(s, z, ok);
        checks++; if (!ok || s !== ref_synd(a)) begin failures++; $display("FAIL b2b_first got=%0h exp=%0h", s, ref_synd(a)); end
        pop_head(s, z, ok);
        checks++; if (!ok || s !== ref_synd(b)) begin failures++; $display("FAIL b2b_second got=%0h exp=%0h", s, ref_synd(b)); end
        exp_count += 2;
    endtask

    task automatic test_backpressure();
        cw_t           a, b, c;
        logic [SW-1:0] s;
        logic          z;
        bit            ok;
        int            w;
        rand_cw(a);
        rand_cw(b);
        rand_cw(c);
        bus.synd_ready = 1'b0;
        send_cw(a, ok, w);
        send_cw(b, ok, w);
        bus.in_valid = 1'b1;
        bus.in_sop   = 1'b1;
        bus.in_data  = c[0];
        tick();
        tick();
        checks++; if (bus.synd_valid !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got v=%0b rdy=%0b exp 1/0", bus.synd_valid, bus.in_ready); end
        repeat (3) tick();
        checks++; if (bus.in_ready !== 1'b0 || bus.synd_out !== ref_synd(a)) begin failures++; $display("FAIL bp_hold got rdy=%0b head=%0h exp 0/%0h", bus.in_ready, bus.synd_out, ref_synd(a)); end
        s = bus.synd_out;
        bus.synd_ready = 1'b1;
        tick();
        bus.synd_ready = 1'b0;
        checks++; if (s !== ref_synd(a)) begin failures++; $display("FAIL bp_pop_a got=%0h exp=%0h", s, ref_synd(a)); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after_pop got=%0b exp=1", bus.in_ready); end
        send_cw(c, ok, w);
        checks++; if (w != 0) begin failures++; $display("FAIL bp_c_accept got_wait=%0d exp_wait=0", w); end
        pop_head(s, z, ok);
        checks++; if (!ok || s !== ref_synd(b)) begin failures++; $display("FAIL bp_pop_b got=%0h exp=%0h", s, ref_synd(b)); end
        pop_head(s, z, ok);
        checks++; if (!ok || s !== ref_synd(c)) begin failures++; $display("FAIL bp_pop_c got=%0h exp=%0h", s, ref_synd(c)); end
        exp_count += 3;
        checks++; if (cw_count !== 16'(exp_count)) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", cw_count, exp_count); end
    endtask

    task automatic test_abort_valid();
        cw_t           cw;
        logic [SW-1:0] s;
        logic          z;
        bit            ok;
        int            w;
        for (int b = 0; b < CWB; b++) cw[b] = 32'h0;
        cw[0] = 32'h1;
        send_beat(cw[0], 1'b1, ok, w);
        send_beat(cw[1], 1'b0, ok, w);
        idle_inputs();
        tick();
        checks++; if (frame_err !== 1'b1 || dp_reset !== 1'b1) begin failures++; $display("FAIL abort_pulse got err=%0b dpr=%0b exp 1/1", frame_err, dp_reset); end
        tick();
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL abort_pulse_len got=%0b exp=0", frame_err); end
        repeat (4) tick();
        checks++; if (bus.synd_valid !== 1'b0 || cw_count !== 16'(exp_count)) begin failures++; $display("FAIL abort_no_write got v=%0b cnt=%0d exp 0/%0d", bus.synd_valid, cw_count, exp_count); end
        send_cw(cw, ok, w);
        pop_head(s, z, ok);
        exp_count++;
        checks++; if (!ok || s !== ref_synd(cw) || z !== 1'b0) begin failures++; $display("FAIL abort_recover got=%0h exp=%0h", s, ref_synd(cw)); end
    endtask

    task automatic test_framing();
        cw_t cw;
        bit  ok;
        int  w;
        int  errs;
        rand_cw(cw);
        send_beat(32'hDEAD_BEEF, 1'b0, ok, w);
        idle_inputs();
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL frame_idle_nosop got=%0b exp=1", frame_err); end
        tick();
        checks++; if (frame_err !== 1'b0 || dp_reset !== 1'b1) begin failures++; $display("FAIL frame_idle_after got err=%0b dpr=%0b exp 0/1", frame_err, dp_reset); end
        send_beat(cw[0], 1'b1, ok, w);
        send_beat(cw[1], 1'b1, ok, w);
        idle_inputs();
        checks++; if (frame_err !== 1'b1 || dp_reset !== 1'b1) begin failures++; $display("FAIL frame_run_sop got err=%0b dpr=%0b exp 1/1", frame_err, dp_reset); end
        errs = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (frame_err !== 1'b0) errs++;
        end
        checks++; if (errs != 0) begin failures++; $display("FAIL frame_single_pulse got_extra=%0d exp=0", errs); end
        checks++; if (bus.synd_valid !== 1'b0 || cw_count !== 16'(exp_count) || bus.in_ready !== 1'b1 || dp_reset !== 1'b1) begin
            failures++; $display("FAIL frame_idle_state got v=%0b cnt=%0d rdy=%0b dpr=%0b exp 0/%0d/1/1", bus.synd_valid, cw_count, bus.in_ready, dp_reset, exp_count);
        end
    endtask

    task automatic test_reset_mid();
        cw_t           a, b;
        logic [SW-1:0] s;
        logic          z;
        bit            ok;
        int            w;
        rand_cw(a);
        rand_cw(b);
        bus.synd_ready = 1'b0;
        send_cw(a, ok, w);
        send_beat(b[0], 1'b1, ok, w);
        send_beat(b[1], 1'b0, ok, w);
        bus.in_data = b[2];
        bus.in_sop  = 1'b0;
        reset = 1'b1;
        tick();
        checks++; if (bus.synd_valid !== 1'b0 || dp_reset !== 1'b1 || bus.in_ready !== 1'b0 || cw_count !== 16'd0) begin
            failures++; $display("FAIL midreset got v=%0b dpr=%0b rdy=%0b cnt=%0d exp 0/1/0/0", bus.synd_valid, dp_reset, bus.in_ready, cw_count);
        end
        idle_inputs();
        reset = 1'b0;
        tick();
        send_cw(b, ok, w);
        pop_head(s, z, ok);
        checks++; if (!ok || s !== ref_synd(b)) begin failures++; $display("FAIL midreset_recover got=%0h exp=%0h", s, ref_synd(b)); end
        checks++; if (cw_count !== 16'd1) begin failures++; $display("FAIL midreset_count got=%0d exp=1", cw_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        build_tables();
        reset = 1'b1;
        bus.synd_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_zero_cw();
        test_single_error();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_abort_valid();
        test_framing();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
